// File: rtl/mul_pkg.sv
// mul_pkg: shared FSM states, class flags and IEEE-style constants for the sequential multiplier
package mul_pkg;

  typedef enum logic [2:0] {IDLE, CLASS, ITER, NORM, DONE} state_t;

  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
  } cls_t;

  function automatic int bias_f(input int expo_w);
    return (1 << (expo_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN {0, all-ones exponent, top mantissa bit}, returned wide and sliced by the user
  function automatic logic [63:0] qnan_f(input int expo_w, input int mant_w);
    return (((64'd1 << expo_w) - 64'd1) << mant_w) | (64'd1 << (mant_w - 1));
  endfunction

endpackage

// File: rtl/mul_seq_norm.sv
// mul_seq_norm: normalizes the raw mantissa product, rounds to nearest-even and range-checks the exponent
module mul_seq_norm #(
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23
) (
  input  logic [2*MANT_W+1:0]        p_i,
  input  logic signed [EXPO_W+1:0]   e_i,
  input  logic                       sign_i,
  output logic [EXPO_W+MANT_W:0]     r_op_o,
  output logic                       ovf_o,
  output logic                       unf_o
);

  localparam int PW = 2 * MANT_W + 2;
  localparam int EW2 = EXPO_W + 2;
  localparam logic signed [EW2-1:0] EMAX = EW2'((1 << EXPO_W) - 1);

  logic                  hi;
  logic                  guard;
  logic                  lsb;
  logic                  sticky;
  logic                  up;
  logic [MANT_W-1:0]     mant;
  logic [MANT_W:0]       sum;
  logic signed [EW2-1:0] ef;

  // A product in [2,4) drops one extra bit into the guard/sticky window and bumps the exponent
  always_comb begin
    hi = p_i[PW-1];
    mant = hi ? p_i[PW-2 -: MANT_W] : p_i[PW-3 -: MANT_W];
    guard = hi ? p_i[MANT_W] : p_i[MANT_W-1];
    lsb = hi ? p_i[MANT_W+1] : p_i[MANT_W];
    sticky = hi ? |p_i[MANT_W-1:0] : |p_i[MANT_W-2:0];
    up = guard & (sticky | lsb);
    sum = {1'b0, mant} + {{MANT_W{1'b0}}, up};
    ef = e_i + EW2'(hi) + EW2'(sum[MANT_W]);
    ovf_o = ef >= EMAX;
    unf_o = ef[EW2-1] || ef == '0;
    r_op_o = ovf_o ? {sign_i, {EXPO_W{1'b1}}, {MANT_W{1'b0}}} :
             unf_o ? {sign_i, {(EXPO_W+MANT_W){1'b0}}} :
                     {sign_i, ef[EXPO_W-1:0], sum[MANT_W-1:0]};
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: handshaked multiply controller with special-case fast path and shift-add mantissa core
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXPO_W+MANT_W:0]   a_op,
  input  logic [EXPO_W+MANT_W:0]   b_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXPO_W+MANT_W:0]   r_op,
  output logic                     r_invalid,
  output logic                     r_ovf,
  output logic                     r_unf
);

  localparam int W = 1 + EXPO_W + MANT_W;
  localparam int M = MANT_W + 1;
  localparam int EW2 = EXPO_W + 2;
  localparam int CW = $clog2(MANT_W + 1);
  localparam int BIAS = bias_f(EXPO_W);
  localparam logic [63:0] QNAN64 = qnan_f(EXPO_W, MANT_W);
  localparam logic [W-1:0] QNAN = QNAN64[W-1:0];

  state_t                state_q;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic [W-1:0]          a_q;
  logic [W-1:0]          b_q;
  logic [W-1:0]          r_op_q;
  logic                  r_invalid_q;
  logic                  r_ovf_q;
  logic                  r_unf_q;
  logic [CW-1:0]         cnt_q;
  logic [M-1:0]          mcand_q;
  logic [2*M-1:0]        prod_q;
  logic [2*M-1:0]        prod_d;
  logic signed [EW2-1:0] e_q;
  logic signed [EW2-1:0] e_d;
  logic                  sign_q;
  logic                  sign_d;
  logic [EXPO_W-1:0]     ea;
  logic [EXPO_W-1:0]     eb;
  logic [MANT_W-1:0]     ma;
  logic [MANT_W-1:0]     mb;
  cls_t                  ca;
  cls_t                  cb;
  logic                  invalid;
  logic                  special;
  logic [W-1:0]          spec_r;
  logic [M:0]            add_s;
  logic [W-1:0]          n_r;
  logic                  n_ovf;
  logic                  n_unf;

  assign ea = a_q[W-2 -: EXPO_W];
  assign eb = b_q[W-2 -: EXPO_W];
  assign ma = a_q[MANT_W-1:0];
  assign mb = b_q[MANT_W-1:0];

  // Operand classification, special-result selection and the unbiased exponent sum
  always_comb begin
    ca.zero = ea == '0;
    ca.inf = &ea && ma == '0;
    ca.nan = &ea && ma != '0;
    cb.zero = eb == '0;
    cb.inf = &eb && mb == '0;
    cb.nan = &eb && mb != '0;
    sign_d = a_q[W-1] ^ b_q[W-1];
    invalid = ca.nan | cb.nan | (ca.zero & cb.inf) | (ca.inf & cb.zero);
    special = |{ca, cb};
    spec_r = invalid ? QNAN :
             (ca.inf | cb.inf) ? {sign_d, {EXPO_W{1'b1}}, {MANT_W{1'b0}}} :
                                 {sign_d, {(W-1){1'b0}}};
    e_d = EW2'(ea) + EW2'(eb) - EW2'(BIAS);
  end

  // One shift-add step: the multiplier sits in the low half of the product and is consumed LSB first
  always_comb begin
    add_s = {1'b0, prod_q[2*M-1:M]} + {1'b0, prod_q[0] ? mcand_q : {M{1'b0}}};
    prod_d = {add_s, prod_q[M-1:1]};
  end

  mul_seq_norm #(
    .EXPO_W(EXPO_W),
    .MANT_W(MANT_W)
  ) u_norm (
    .p_i   (prod_q),
    .e_i   (e_q),
    .sign_i(sign_q),
    .r_op_o(n_r),
    .ovf_o (n_ovf),
    .unf_o (n_unf)
  );

  // Control FSM with datapath registers; results are held untouched for the whole DONE state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      r_op_q <= '0;
      r_invalid_q <= 1'b0;
      r_ovf_q <= 1'b0;
      r_unf_q <= 1'b0;
      cnt_q <= '0;
      mcand_q <= '0;
      prod_q <= '0;
      e_q <= '0;
      sign_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q <= a_op;
          b_q <= b_op;
          in_ready_q <= 1'b0;
          state_q <= CLASS;
        end
        CLASS: begin
          sign_q <= sign_d;
          e_q <= e_d;
          cnt_q <= '0;
          mcand_q <= {1'b1, ma};
          prod_q <= {{M{1'b0}}, 1'b1, mb};
          if (special) begin
            r_op_q <= spec_r;
            r_invalid_q <= invalid;
            r_ovf_q <= 1'b0;
            r_unf_q <= 1'b0;
            out_valid_q <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= ITER;
          end
        end
        ITER: begin
          prod_q <= prod_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(MANT_W)) state_q <= NORM;
        end
        NORM: begin
          r_op_q <= n_r;
          r_invalid_q <= 1'b0;
          r_ovf_q <= n_ovf;
          r_unf_q <= n_unf;
          out_valid_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign r_op = r_op_q;
  assign r_invalid = r_invalid_q;
  assign r_ovf = r_ovf_q;
  assign r_unf = r_unf_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: directed and randomized checks of mul_seq_ctrl against an arithmetic reference model
module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a_op = '0;
  logic [31:0] b_op = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] r_op;
  logic        r_invalid;
  logic        r_ovf;
  logic        r_unf;

  int checks = 0;
  int failures = 0;

  mul_seq_ctrl #(.EXPO_W(8), .MANT_W(23)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_op     (a_op),
    .b_op     (b_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .r_op     (r_op),
    .r_invalid(r_invalid),
    .r_ovf    (r_ovf),
    .r_unf    (r_unf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  logic [31:0] da [10] = '{32'h3FC00000, 32'h00000000, 32'h7FC00001, 32'h7F000000, 32'h00800000,
                           32'h80800000, 32'h3FC00001, 32'h3F800001, 32'hC0000000, 32'h80000000};
  logic [31:0] db [10] = '{32'h40000000, 32'h7F800000, 32'h3F800000, 32'h7F000000, 32'h00800000,
                           32'h00800000, 32'h3F800001, 32'h3F800001, 32'h7F800000, 32'h3F800000};
  logic [31:0] dr [10] = '{32'h40400000, 32'h7FC00000, 32'h7FC00000, 32'h7F800000, 32'h00000000,
                           32'h80000000, 32'h3FC00003, 32'h3F800002, 32'hFF800000, 32'h80000000};
  logic [2:0]  df [10] = '{3'b000, 3'b100, 3'b100, 3'b010, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
  int          dl [10] = '{27, 2, 2, 27, 27, 27, 27, 27, 2, 2};

  // Reference: {special, invalid, ovf, unf, result} from plain integer arithmetic on single-precision fields
  function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic sign, za, zb, ia, ib, na, nb;
    longint unsigned p, keep, rem, half;
    int e, sh;
    sign = a[31] ^ b[31];
    za = a[30:23] == 0;
    zb = b[30:23] == 0;
    ia = a[30:23] == 8'hFF && a[22:0] == 0;
    ib = b[30:23] == 8'hFF && b[22:0] == 0;
    na = a[30:23] == 8'hFF && a[22:0] != 0;
    nb = b[30:23] == 8'hFF && b[22:0] != 0;
    if (na || nb || (za && ib) || (ia && zb)) return {4'b1100, 32'h7FC00000};
    if (ia || ib) return {4'b1000, sign, 8'hFF, 23'h0};
    if (za || zb) return {4'b1000, sign, 31'h0};
    p = (64'(a[22:0]) + 64'h800000) * (64'(b[22:0]) + 64'h800000);
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    sh = 23;
    if (p >= (64'd1 << 47)) begin
      sh = 24;
      e = e + 1;
    end
    keep = p >> sh;
    rem = p - (keep << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && keep[0])) keep = keep + 1;
    if (keep >= (64'd1 << 24)) begin
      keep = keep >> 1;
      e = e + 1;
    end
    if (e >= 255) return {4'b0010, sign, 8'hFF, 23'h0};
    if (e <= 0) return {4'b0001, sign, 31'h0};
    return {4'b0000, sign, e[7:0], keep[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [7:0] e;
    logic [31:0] m;
    int k;
    k = $urandom_range(0, 9);
    m = $urandom;
    e = k == 0 ? 8'h00 : k == 1 ? 8'hFF : k == 2 ? 8'($urandom_range(1, 20)) :
        k == 3 ? 8'($urandom_range(230, 254)) : 8'($urandom_range(100, 154));
    if (k == 1 && $urandom_range(0, 1) == 1) m = 0;
    return {m[31], e, m[22:0]};
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic [2:0] fl, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    in_valid = 1'b1;
    a_op = a;
    b_op = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    r = r_op;
    fl = {r_invalid, r_ovf, r_unf};
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (r_op !== 32'h0) begin failures++; $display("FAIL reset_r_op got %h exp 0", r_op); end
    checks++; if ({r_invalid, r_ovf, r_unf} !== 3'b000) begin failures++; $display("FAIL reset_flags got %b exp 000", {r_invalid, r_ovf, r_unf}); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] r;
    logic [2:0] fl;
    int lat;
    for (int i = 0; i < 10; i++) begin
      run_op(da[i], db[i], r, fl, lat);
      checks++; if (r !== dr[i]) begin failures++; $display("FAIL directed_r_op[%0d] got %h exp %h", i, r, dr[i]); end
      checks++; if (fl !== df[i]) begin failures++; $display("FAIL directed_flags[%0d] got %b exp %b", i, fl, df[i]); end
      checks++; if (lat !== dl[i]) begin failures++; $display("FAIL directed_latency[%0d] got %0d exp %0d", i, lat, dl[i]); end
      drain();
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r;
    logic [2:0] fl;
    logic [35:0] x;
    int lat;
    for (int i = 0; i < 40; i++) begin
      a = rnd_op();
      b = rnd_op();
      x = ref_mul(a, b);
      run_op(a, b, r, fl, lat);
      checks++; if (r !== x[31:0]) begin failures++; $display("FAIL random_r_op %h*%h got %h exp %h", a, b, r, x[31:0]); end
      checks++; if (fl !== x[34:32]) begin failures++; $display("FAIL random_flags %h*%h got %b exp %b", a, b, fl, x[34:32]); end
      checks++; if (lat !== (x[35] ? 2 : 27)) begin failures++; $display("FAIL random_latency %h*%h got %0d exp %0d", a, b, lat, x[35] ? 2 : 27); end
      drain();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] r;
    logic [2:0] fl;
    int lat;
    run_op(32'h3FC00001, 32'h3F800001, r, fl, lat);
    checks++; if (r !== 32'h3FC00003) begin failures++; $display("FAIL bp_r_op got %h exp 3fc00003", r); end
    in_valid = 1'b1;
    a_op = 32'h40000000;
    b_op = 32'h40000000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (r_op !== 32'h3FC00003) begin failures++; $display("FAIL bp_hold_r_op[%0d] got %h exp 3fc00003", i, r_op); end
      checks++; if ({r_invalid, r_ovf, r_unf, out_valid, in_ready} !== 5'b00010) begin
        failures++; $display("FAIL bp_hold_ctrl[%0d] got %b exp 00010", i, {r_invalid, r_ovf, r_unf, out_valid, in_ready}); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin failures++; $display("FAIL bp_release got %b exp 01", {out_valid, in_ready}); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    logic [2:0] fl;
    int lat;
    in_valid = 1'b1;
    a_op = 32'h40400000;
    b_op = 32'h40000000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin failures++; $display("FAIL midreset_ctrl got %b exp 01", {out_valid, in_ready}); end
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(32'h40000000, 32'h40000000, r, fl, lat);
    checks++; if (r !== 32'h40800000) begin failures++; $display("FAIL midreset_r_op got %h exp 40800000", r); end
    checks++; if (fl !== 3'b000) begin failures++; $display("FAIL midreset_flags got %b exp 000", fl); end
    checks++; if (lat !== 27) begin failures++; $display("FAIL midreset_latency got %0d exp 27", lat); end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [35:0] q[$];
    logic [35:0] x;
    logic [31:0] a, b;
    int n_acc, n_done, cyc, last_acc, last_lat, overlap;
    logic acc;
    n_acc = 0;
    n_done = 0;
    cyc = 0;
    last_acc = -1;
    last_lat = 0;
    overlap = 0;
    out_ready = 1'b1;
    a = rnd_op();
    b = rnd_op();
    in_valid = 1'b1;
    a_op = a;
    b_op = b;
    while (n_done < 6 && cyc < 400) begin
      if (in_ready && out_valid) overlap++;
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        x = q.size() > 0 ? q.pop_front() : 36'hF_FFFF_FFFF;
        checks++; if ({r_invalid, r_ovf, r_unf, r_op} !== x[34:0]) begin
          failures++; $display("FAIL b2b_result[%0d] got %h exp %h", n_done, {r_invalid, r_ovf, r_unf, r_op}, x[34:0]); end
        n_done++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        x = ref_mul(a, b);
        q.push_back(x);
        if (last_acc >= 0) begin
          checks++; if (cyc - last_acc !== last_lat + 1) begin
            failures++; $display("FAIL b2b_spacing[%0d] got %0d exp %0d", n_acc, cyc - last_acc, last_lat + 1); end
        end
        last_acc = cyc;
        last_lat = x[35] ? 2 : 27;
        n_acc++;
        if (n_acc < 6) begin
          a = rnd_op();
          b = rnd_op();
          a_op = a;
          b_op = b;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++; if (n_done !== 6) begin failures++; $display("FAIL b2b_completed got %0d exp 6", n_done); end
    checks++; if (overlap !== 0) begin failures++; $display("FAIL b2b_ready_overlap got %0d exp 0", overlap); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
